// File: rtl/fp_div_pkg.sv
// Shared encodings and helpers for the divider result normaliser.
// Rounding modes, special-value codes, flag bundle, field constants.
package fp_div_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  typedef enum logic [1:0] {
    SP_NORM = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_e;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } flags_t;

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int qnan_frac(input int mant_w);
    return 1 << (mant_w - 1);
  endfunction

endpackage

// File: rtl/fp_div_round_normalizer_inc.sv
// Round-increment decision from lsb/guard/round/sticky, sign and mode.
// Purely combinational; used in the rounding stage.
module fp_round_inc
  import fp_div_pkg::*;
(
  input  logic   lsb,
  input  logic   guard,
  input  logic   rnd,
  input  logic   sticky,
  input  logic   sign,
  input  rmode_e rmode,
  output logic   inc
);

  logic tail;

  assign tail = guard | rnd | sticky;

  always_comb begin
    inc = 1'b0;
    unique case (rmode)
      RM_RNE:  inc = guard & (rnd | sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & tail;
      RM_RDN:  inc = sign & tail;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_div_round_normalizer.sv
// Divider result normaliser: S1 normalise/denormalise, S2 round/pack.
// Two-stage valid/ready pipeline, one result per cycle.
module fp_div_round_normalizer
  import fp_div_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+1:0]      exp_in,
  input  logic [MANT_W+2:0]     q_in,
  input  logic                  sticky_in,
  input  logic                  sign_in,
  input  logic [1:0]            special_in,
  input  logic [1:0]            rmode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] result,
  output logic [2:0]            flags
);

  localparam int EXTW = EXP_W + 2;
  localparam int QW   = MANT_W + 3;
  localparam int NW   = EXTW + 1;
  localparam int SW   = NW + MANT_W;
  localparam logic [NW-1:0] EXP_MAX =
    NW'(exp_max(EXP_W));
  localparam logic [MANT_W-1:0] QNAN_FRAC =
    MANT_W'(qnan_frac(MANT_W));

  logic s1_v;
  logic s2_v;
  logic ld2;
  logic adv1;

  assign ld2       = ~s2_v | out_ready;
  assign adv1      = s1_v & ld2;
  assign in_ready  = ~s1_v | adv1;
  assign out_valid = s2_v;

  logic [NW-1:0]   e_ext;
  logic [NW-1:0]   e_n;
  logic [NW-1:0]   sh_raw;
  logic [NW-1:0]   sh;
  logic [QW-1:0]   q_n;
  logic [2*QW-1:0] q_sh;
  logic [QW-1:0]   m_n;
  logic [NW-1:0]   eb_n;
  logic            tiny_n;
  logic            st_n;

  assign e_ext  = {exp_in[EXTW-1], exp_in};
  assign q_n    = q_in[QW-1] ? q_in
                             : {q_in[QW-2:0], 1'b0};
  assign e_n    = q_in[QW-1] ? e_ext
                             : e_ext - NW'(1);
  assign tiny_n = e_n[NW-1] | (e_n == '0);

  // Shift of QW or more flushes every bit into sticky.
  assign sh_raw = NW'(1) - e_n;
  assign sh     = (sh_raw > NW'(QW)) ? NW'(QW)
                                     : sh_raw;
  assign q_sh   = {q_n, {QW{1'b0}}} >> sh;

  assign m_n  = tiny_n ? q_sh[2*QW-1:QW] : q_n;
  assign st_n = sticky_in
              | (tiny_n & (|q_sh[QW-1:0]));

  // Exponent held one below the field; hidden bit adds it back.
  assign eb_n = tiny_n ? '0 : e_n - NW'(1);

  logic [QW-1:0] s1_m;
  logic [NW-1:0] s1_eb;
  logic          s1_st;
  logic          s1_tiny;
  logic          s1_sign;
  special_e      s1_sp;
  rmode_e        s1_rm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_m    <= '0;
      s1_eb   <= '0;
      s1_st   <= 1'b0;
      s1_tiny <= 1'b0;
      s1_sign <= 1'b0;
      s1_sp   <= SP_NORM;
      s1_rm   <= RM_RNE;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
      end
      if (in_valid & in_ready) begin
        s1_m    <= m_n;
        s1_eb   <= eb_n;
        s1_st   <= st_n;
        s1_tiny <= tiny_n;
        s1_sign <= sign_in;
        s1_sp   <= special_e'(special_in);
        s1_rm   <= rmode_e'(rmode);
      end
    end
  end

  logic                  inc;
  logic                  inexact;
  logic                  ovf;
  logic                  to_inf;
  logic [SW-1:0]         sum;
  logic [NW-1:0]         e_rnd;
  logic [EXP_W+MANT_W:0] res_n;
  flags_t                fl_n;

  fp_round_inc u_inc (
    .lsb    (s1_m[2]),
    .guard  (s1_m[1]),
    .rnd    (s1_m[0]),
    .sticky (s1_st),
    .sign   (s1_sign),
    .rmode  (s1_rm),
    .inc    (inc)
  );

  assign inexact = (|s1_m[1:0]) | s1_st;

  // Fraction carry ripples straight into the exponent field.
  assign sum   = {s1_eb, {MANT_W{1'b0}}}
               + SW'(s1_m[QW-1:2])
               + SW'(inc);
  assign e_rnd = sum[SW-1:MANT_W];
  assign ovf   = e_rnd >= EXP_MAX;

  assign to_inf = (s1_rm == RM_RNE)
                | ((s1_rm == RM_RUP) & ~s1_sign)
                | ((s1_rm == RM_RDN) & s1_sign);

  always_comb begin
    res_n = '0;
    fl_n  = '0;
    unique case (s1_sp)
      SP_ZERO: begin
        res_n = {s1_sign, {EXP_W{1'b0}},
                 {MANT_W{1'b0}}};
      end
      SP_INF: begin
        res_n = {s1_sign, {EXP_W{1'b1}},
                 {MANT_W{1'b0}}};
      end
      SP_NAN: begin
        res_n = {1'b0, {EXP_W{1'b1}}, QNAN_FRAC};
      end
      default: begin
        if (ovf) begin
          fl_n = {1'b1, 1'b0, 1'b1};
          if (to_inf) begin
            res_n = {s1_sign, {EXP_W{1'b1}},
                     {MANT_W{1'b0}}};
          end else begin
            res_n = {s1_sign, {(EXP_W-1){1'b1}},
                     1'b0, {MANT_W{1'b1}}};
          end
        end else begin
          fl_n  = {1'b0, s1_tiny & inexact,
                   inexact};
          res_n = {s1_sign, e_rnd[EXP_W-1:0],
                   sum[MANT_W-1:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (ld2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result <= res_n;
        flags  <= fl_n;
      end
    end
  end

endmodule
